mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multi-cycle RV32M execution unit. It sits in the EX stage beside the single-cycle ALU and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Uses a start/busy/done handshake. The hazard unit stalls IF/ID/EX while busy is high and writes Result into EX/MEM when done pulses.
- Fixed latency for every op and operand value, so stall control stays simple.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Flush  input  1  synchronous abort (branch/exception squash of EX).
- MdOp  input  3  operation = instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Operand1  input  32  rs1 value; sampled with Start.
- Operand2  input  32  rs2 value; sampled with Start.
- Busy  output  1  high from the cycle after Start is accepted until Done.
- Done  output  1  one-cycle pulse; Result is valid in this cycle.
- Result  output  32  registered result; holds its value until the next Done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, Busy=0, Done=0, Result=0, counter=0, and all internal datapath registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if Start=1 and Flush=0 at edge E0:
  - latch MdOp, take operand magnitudes (signedness per op; MULHSU treats Operand1 signed, Operand2 unsigned), record result sign and the special-case flags;
  - go to CALC with counter=0.
- CALC: one iteration per edge for exactly 32 edges (E0+1..E0+32), then go to FIX.
  - Multiply: radix-2 shift-add on the unsigned magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract on the unsigned magnitudes, producing a 32-bit quotient and 32-bit remainder.
- FIX (edge E0+33): apply sign correction and select the result, register Result, go to DONE.
  - Multiply sign correction: two's complement of the 64-bit product when the result is negative.
  - Divide sign correction: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits; DIV/DIVU return quotient; REM/REMU return remainder.
- DONE: Done=1 for exactly one cycle (the cycle after E0+33); next edge returns to IDLE.
- Latency: Start sampled at E0 means Done is high in the cycle after edge E0+33. Busy is high from after E0 through the Done cycle inclusive; Busy=0 in IDLE.
- Start while not IDLE: ignored, no queuing. A new Start may be accepted in IDLE the cycle after Done.
- Divide by zero (Operand2=0): overrides the normal result.
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return Operand1 unchanged.
  - Latency unchanged.
- Signed overflow (DIV/REM with Operand1=0x80000000, Operand2=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0. Latency unchanged.
- Flush=1 at any edge:
  - next state IDLE, Busy=0, Done is not asserted, Result keeps its previous value;
  - Flush overrides a Start in the same cycle;
  - Flush during DONE suppresses nothing already visible but still forces IDLE.
- Operand1/Operand2/MdOp may change freely after acceptance; internal copies are used.
- Reset asserted mid-operation aborts immediately to the reset values; no Done is produced.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> Done exactly 34 cycles after the Start edge (counting the Start edge as cycle 0: Done in cycle 34), Result=0xFFFFFFEB; Busy high for the 33 cycles before plus the Done cycle.
- MULH / MULHSU / MULHU with 0x80000000 x 0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000; REM -> 0. Latency identical to the normal cases.
- Start held high for the whole operation, with operands changed mid-op -> only one Done, computed from the originally latched operands; a back-to-back Start in the first IDLE cycle after Done is accepted.
- Flush at cycle 10 of CALC, then a new MUL 3x4 -> no Done for the first op, Result holds its old value until the second Done gives 0x0000000C. rst_n pulsed low mid-CALC -> Busy=0, Result=0 asynchronously.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the EX stage.
// Every operation takes the same number of cycles: 1 accept edge, 32 iteration
// edges, 1 fix-up edge, then a one-cycle Done pulse. A fixed latency keeps
// the hazard unit's stall logic trivial.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      MdOp,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        op;
    logic [CNT_W-1:0]  cnt;
    // multiply: {partial product, remaining multiplier bits}
    // divide:   {partial remainder, dividend bits shifting into quotient}
    logic [2*XLEN-1:0] acc;
    // multiplicand magnitude for multiply, divisor magnitude for divide
    logic [XLEN-1:0]   mcand;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic              div_ovf;

    // operand decode for the accept edge
    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    // one iteration step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    // sign correction and result selection
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quot_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   fix_result;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Decode signedness from funct3 and take operand magnitudes; MULHSU is
    // the only op where the two operands differ in signedness.
    always_comb begin
        is_div   = MdOp[2];
        a_signed = (MdOp != 3'b011) && (MdOp != 3'b101) && (MdOp != 3'b111);
        b_signed = a_signed && (MdOp != 3'b010);
        neg_a    = a_signed && Operand1[XLEN-1];
        neg_b    = b_signed && Operand2[XLEN-1];
        a_mag    = neg_a ? (~Operand1 + 1'b1) : Operand1;
        b_mag    = neg_b ? (~Operand2 + 1'b1) : Operand2;
    end

    // Single iteration: radix-2 shift-add for multiply, restoring
    // shift-subtract for divide, both working on unsigned magnitudes.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_next  = div_ge ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Sign-correct the raw magnitudes and pick the architectural result.
    // A zero divisor leaves the remainder equal to |Operand1| with the
    // dividend's sign restored, which is exactly Operand1.
    always_comb begin
        prod_fixed = neg_res ? (~acc + 1'b1) : acc;
        quot_fixed = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fixed  = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op)
            3'b000:                 fix_result = prod_fixed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fixed[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (div_zero)
                    fix_result = '1;
                else if (div_ovf)
                    fix_result = MIN_NEG;
                else
                    fix_result = quot_fixed;
            end
            default: begin
                if (div_ovf && !div_zero)
                    fix_result = '0;
                else
                    fix_result = rem_fixed;
            end
        endcase
    end

    // Control FSM and datapath registers; Flush aborts from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
        end else if (Flush) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op       <= MdOp;
                        cnt      <= '0;
                        mcand    <= is_div ? b_mag : a_mag;
                        acc      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        neg_res  <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                        div_zero <= is_div && (Operand2 == '0);
                        div_ovf  <= is_div && !MdOp[0] && (Operand1 == MIN_NEG)
                                    && (Operand2 == '1);
                        Busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    Result <= fix_result;
                    Done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed test of mul_div_unit with hand-computed results,
// latency, Busy window, back-to-back start, Flush abort and async reset.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Flush;
    logic [2:0]  MdOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int assert_count = 0;
    int fail_count   = 0;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .Flush    (Flush),
        .MdOp     (MdOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // present a request on the falling edge so it is sampled at the next rise
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        Start    = 1'b1;
        MdOp     = op;
        Operand1 = a;
        Operand2 = b;
    endtask

    // Wait for the accept edge E0, then watch 35 cycles. Cycle i is the
    // interval just after edge E0+i-1; Done belongs in cycle 34 and Busy
    // must be high in cycles 1..34. With hold set, Start stays high and the
    // operands are overwritten in cycle 10 with a second request.
    task automatic waitDone(input bit hold, input logic [2:0] op2,
                            input logic [31:0] a2, input logic [31:0] b2,
                            output int done_cycle, output int done_cnt,
                            output logic [31:0] res, output logic busy_ok);
        @(posedge clk);
        done_cycle = 0;
        done_cnt   = 0;
        res        = 32'h0;
        busy_ok    = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_cycle == 0) begin
                    done_cycle = i;
                    res        = Result;
                end
            end
            if (Busy !== (i <= 34))
                busy_ok = 1'b0;
            if (i == 1 && !hold)
                Start = 1'b0;
            if (i == 10 && hold) begin
                MdOp     = op2;
                Operand1 = a2;
                Operand2 = b2;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected);
        int          dc;
        int          dn;
        logic [31:0] r;
        logic        bok;
        applyStimulus(op, a, b);
        waitDone(1'b0, 3'b000, 32'h0, 32'h0, dc, dn, r, bok);
        checkOutput({tag, " result"}, r, expected);
        checkOutput({tag, " done_cycle"}, 32'(dc), 32'd34);
        checkOutput({tag, " done_count"}, 32'(dn), 32'd1);
        checkOutput({tag, " busy_window"}, {31'h0, bok}, 32'h1);
    endtask

    initial begin
        int          dc;
        int          dn;
        logic [31:0] r;
        logic        bok;

        rst_n    = 1'b0;
        Start    = 1'b0;
        Flush    = 1'b0;
        MdOp     = 3'b000;
        Operand1 = 32'h0;
        Operand2 = 32'h0;

        #3;
        checkOutput("reset Busy", {31'h0, Busy}, 32'h0);
        checkOutput("reset Done", {31'h0, Done}, 32'h0);
        checkOutput("reset Result", Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] multiply cases");
        runOp("MUL 7x-3",        OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
        runOp("MULH min x -1",   OP_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        runOp("MULHSU min x max",OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runOp("MULHU",           OP_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF);

        $display("[TB] divide cases");
        runOp("DIV -7/2",        OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        runOp("REM -7/2",        OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        runOp("DIVU",            OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC);
        runOp("REMU",            OP_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001);

        $display("[TB] divide by zero and overflow");
        runOp("DIV 5/0",         OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF);
        runOp("REM 5/0",         OP_REM,    32'h00000005, 32'h00000000, 32'h00000005);
        runOp("DIV -7/0",        OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF);
        runOp("REM -7/0",        OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9);
        runOp("DIVU 5/0",        OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF);
        runOp("DIV overflow",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runOp("REM overflow",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        $display("[TB] Start held high, operands changed mid-op, back-to-back");
        applyStimulus(OP_MUL, 32'd6, 32'd7);
        waitDone(1'b1, OP_DIVU, 32'd100, 32'd7, dc, dn, r, bok);
        checkOutput("held first result", r, 32'h0000002A);
        checkOutput("held first done_cycle", 32'(dc), 32'd34);
        checkOutput("held first done_count", 32'(dn), 32'd1);
        checkOutput("held first busy_window", {31'h0, bok}, 32'h1);
        waitDone(1'b0, 3'b000, 32'h0, 32'h0, dc, dn, r, bok);
        checkOutput("back-to-back result", r, 32'h0000000E);
        checkOutput("back-to-back done_cycle", 32'(dc), 32'd34);
        checkOutput("back-to-back busy_window", {31'h0, bok}, 32'h1);

        $display("[TB] Flush mid-CALC");
        applyStimulus(OP_MUL, 32'h00001234, 32'h00000010);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        checkOutput("flush Busy", {31'h0, Busy}, 32'h0);
        checkOutput("flush Result held", Result, 32'h0000000E);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done === 1'b1)
                dn++;
        end
        checkOutput("flush no Done", 32'(dn), 32'd0);
        checkOutput("flush Result still held", Result, 32'h0000000E);

        @(negedge clk);
        Start    = 1'b1;
        Flush    = 1'b1;
        MdOp     = OP_MUL;
        Operand1 = 32'd9;
        Operand2 = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        Flush = 1'b0;
        checkOutput("flush beats Start", {31'h0, Busy}, 32'h0);

        runOp("MUL 3x4 after flush", OP_MUL, 32'd3, 32'd4, 32'h0000000C);

        $display("[TB] asynchronous reset mid-CALC");
        applyStimulus(OP_MUL, 32'd5, 32'd5);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre-reset Busy", {31'h0, Busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset Busy", {31'h0, Busy}, 32'h0);
        checkOutput("async reset Result", Result, 32'h0);
        checkOutput("async reset Done", {31'h0, Done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done === 1'b1)
                dn++;
        end
        checkOutput("reset no Done", 32'(dn), 32'd0);

        runOp("MULHU after reset", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
